seq_blinker_bank: RTL and testbench



---
 rtl/seq_blinker_bank.sv | 95 +++++++++
 tb/tb_seq_blinker_bank.sv | 112 +++++++++++
 2 files changed

// File: rtl/seq_blinker_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// seq_blinker_bank : five independent free-running square waves, i_clk/(2*HALFn).
// Optional build macro SEQ_BLINKER_HEARTBEAT_EN adds o_beat (pulse per ch-1 toggle).
// Revision 1.0
// ============================================================================
module seq_blinker_bank #(
  parameter int HALF1 = 50,
  parameter int HALF2 = 25,
  parameter int HALF3 = 17,
  parameter int HALF4 = 10,
  parameter int HALF5 = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic outreg1,
  output logic outreg2,
  output logic outreg3,
  output logic outreg4,
  output logic outreg5
`ifdef SEQ_BLINKER_HEARTBEAT_EN
  ,
  output logic o_beat
`endif
);

  localparam int HALF_A [5] = '{HALF1, HALF2, HALF3, HALF4, HALF5};

  if (HALF1 < 1 || HALF2 < 1 || HALF3 < 1 || HALF4 < 1 || HALF5 < 1) begin : g_bad_param
    $error("seq_blinker_bank: every HALFn must be >= 1");
  end

  logic [4:0] out_w;

`ifdef SEQ_BLINKER_HEARTBEAT_EN
  logic wrap1_w;
`endif

  for (genvar g = 0; g < 5; g++) begin : g_chan
    localparam int H = HALF_A[g];
    localparam int W = (H > 1) ? $clog2(H) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         wrap;

    always_comb begin
      wrap  = (cnt_q == W'(H - 1));
      cnt_d = wrap ? '0 : cnt_q + W'(1);
      out_d = out_q ^ wrap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
      end
    end

    assign out_w[g] = out_q;

`ifdef SEQ_BLINKER_HEARTBEAT_EN
    if (g == 0) begin : g_wrap1
      assign wrap1_w = wrap;
    end
`endif
  end

  assign outreg1 = out_w[0];
  assign outreg2 = out_w[1];
  assign outreg3 = out_w[2];
  assign outreg4 = out_w[3];
  assign outreg5 = out_w[4];

`ifdef SEQ_BLINKER_HEARTBEAT_EN
  // Registered alongside outreg1, so it is high exactly in the cycle outreg1 changes.
  logic beat_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_q <= 1'b0;
    end else begin
      beat_q <= wrap1_w;
    end
  end

  assign o_beat = beat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_blinker_bank.sv
`timescale 1ns/100ps
`default_nettype none
// Scoreboard bench for seq_blinker_bank: expected outputs derived from edges since reset release.
module tb_seq_blinker_bank;

`ifdef SEQ_BLINKER_HEARTBEAT_EN
  localparam int P1 = 1, P2 = 2, P3 = 3, P4 = 4, P5 = 5;
`else
  localparam int P1 = 50, P2 = 25, P3 = 17, P4 = 10, P5 = 5;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic o1, o2, o3, o4, o5, beat;
  logic [5:0] obs;

  int unsigned k = 0;
  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #1 clk = ~clk;

  seq_blinker_bank #(P1, P2, P3, P4, P5) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .outreg1 (o1),
    .outreg2 (o2),
    .outreg3 (o3),
    .outreg4 (o4),
    .outreg5 (o5)
`ifdef SEQ_BLINKER_HEARTBEAT_EN
    ,
    .o_beat  (beat)
`endif
  );

`ifndef SEQ_BLINKER_HEARTBEAT_EN
  assign beat = 1'b0;
`endif

  assign obs = {beat, o5, o4, o3, o2, o1};

  // Channel n is high while floor(k/HALFn) is odd; beat follows each multiple of HALF1.
  function automatic logic [5:0] expected(input int unsigned edges, input logic rn);
    int unsigned h [5] = '{P1, P2, P3, P4, P5};
    logic [5:0] e = '0;
    if (rn) begin
      for (int n = 0; n < 5; n++) e[n] = ((edges / h[n]) % 2) == 1;
`ifdef SEQ_BLINKER_HEARTBEAT_EN
      e[5] = (edges > 0) && ((edges % h[0]) == 0);
`endif
    end
    return e;
  endfunction

  // One clock of stimulus: reset level chosen mid-cycle, so assertion is asynchronous.
  task automatic step(input logic rst_level);
    @(posedge clk);
    if (rst_n) k++;
    #0.5;
    rst_n = rst_level;
    if (!rst_level) k = 0;
    exp_q.push_back(expected(k, rst_n));
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t edges=%0d got={beat,o5..o1}=%b expected=%b",
                   $time, k, obs, e);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int i = 0; i < 3500; i++) step(1'b1);
    // Mid-period reset after edge 33, then a fresh release.
    step(1'b0);
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 33; i++) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 120; i++) step(1'b1);
    for (int ep = 0; ep < 25; ep++) begin
      int unsigned run_len = $urandom_range(1, 260);
      int unsigned rst_len = $urandom_range(1, 4);
      for (int i = 0; i < int'(run_len); i++) step(1'b1);
      for (int i = 0; i < int'(rst_len); i++) step(1'b0);
    end
    for (int i = 0; i < 200; i++) step(1'b1);
    @(negedge clk);
    #0.2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
